// File: rtl/cmult_pipe_sm_pkg.sv
// Shared sign-magnitude types and arithmetic helpers for the complex multiplier.
package cmult_pkg;

    localparam int unsigned DATA_W_MAX = 32;
    localparam int unsigned MAG_W      = DATA_W_MAX - 1;
    localparam int unsigned PROD_W     = 2 * MAG_W;

    typedef logic [MAG_W-1:0] mag_t;

    typedef struct packed {
        logic sign;
        mag_t mag;
    } sm_t;

    typedef struct packed {
        sm_t  sum;
        logic ovf;
    } sm_sum_t;

    function automatic logic sm_is_zero(input sm_t x);
        return x.mag == '0;
    endfunction

    // Add two sign-magnitude values whose magnitudes occupy the low mag_w bits.
    function automatic sm_sum_t sm_add(input sm_t a, input sm_t b, input int unsigned mag_w);
        logic [MAG_W:0] full;
        logic [MAG_W:0] lim;
        sm_sum_t        r;
        lim = (MAG_W + 1)'(1) << mag_w;
        r   = '0;
        if (a.sign == b.sign) begin
            full       = {1'b0, a.mag} + {1'b0, b.mag};
            r.sum.sign = a.sign;
        end else if (a.mag >= b.mag) begin
            full       = {1'b0, a.mag} - {1'b0, b.mag};
            r.sum.sign = a.sign;
        end else begin
            full       = {1'b0, b.mag} - {1'b0, a.mag};
            r.sum.sign = b.sign;
        end
        r.ovf     = full >= lim;
        r.sum.mag = mag_t'(full & (lim - (MAG_W + 1)'(1)));
        if (sm_is_zero(r.sum)) begin
            r.sum.sign = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmult_pipe_sm_if.sv
// Operand/result handshake bundle for cmult_pipe_sm.
interface cmult_pipe_sm_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a_re;
    logic [DATA_W-1:0] a_im;
    logic [DATA_W-1:0] b_re;
    logic [DATA_W-1:0] b_im;
    logic              conj_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] s_re;
    logic [DATA_W-1:0] s_im;
    logic              out_ovf;
    logic              ovf_sticky;
    logic              ovf_clr;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, conj_b, out_ready, ovf_clr,
        input  in_ready, out_valid, s_re, s_im, out_ovf, ovf_sticky
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, conj_b, out_ready, ovf_clr,
        output in_ready, out_valid, s_re, s_im, out_ovf, ovf_sticky
    );
endinterface

// File: rtl/cmult_pipe_sm_mul.sv
// Registered magnitude multiply, fixed-point rescale and overflow detect.
// CMULT_SAT_EN selects saturation instead of wrap on overflow.
module sm_mul_scale
    import cmult_pkg::*;
#(
    parameter int unsigned MW     = 31,
    parameter int unsigned FRAC_W = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  sm_t  a,
    input  sm_t  b,
    output sm_t  p,
    output logic ovf
);
    localparam mag_t MAG_MAX = mag_t'((64'(1) << MW) - 64'(1));

    logic [PROD_W-1:0] full;
    logic [PROD_W-1:0] shifted;
    logic              hi;
    mag_t              mag_c;

    // Truncation toward zero falls out of shifting the unsigned magnitude.
    always_comb begin
        full    = PROD_W'(a.mag) * PROD_W'(b.mag);
        shifted = full >> FRAC_W;
        hi      = |(shifted >> MW);
`ifdef CMULT_SAT_EN
        mag_c   = hi ? MAG_MAX : (mag_t'(shifted) & MAG_MAX);
`else
        mag_c   = mag_t'(shifted) & MAG_MAX;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p   <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            p.sign <= a.sign ^ b.sign;
            p.mag  <= mag_c;
            ovf    <= hi;
        end
    end

endmodule

// File: rtl/cmult_pipe_sm.sv
// Three-stage sign-magnitude complex multiplier: S = A*B or A*conj(B).
// Define CMULT_SAT_EN to saturate overflowing components instead of wrapping.
module cmult_pipe_sm
    import cmult_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC_W = 30
) (
    input  logic           clk,
    input  logic           rst,
    cmult_pipe_sm_if.slave bus
);
    localparam int unsigned MW      = DATA_W - 1;
    localparam mag_t        MAG_MAX = mag_t'((64'(1) << MW) - 64'(1));

    function automatic sm_t to_sm(input logic [DATA_W-1:0] x, input logic flip);
        sm_t r;
        r.sign = x[DATA_W-1] ^ flip;
        r.mag  = mag_t'(x) & MAG_MAX;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] from_sm(input sm_t x);
        return {x.sign, (DATA_W - 1)'(x.mag)};
    endfunction

    logic    adv;
    logic    s1_valid;
    logic    s2_valid;
    sm_t     s1_ar, s1_ai, s1_br, s1_bi;
    sm_t     p_rr, p_ii, p_ri, p_ir;
    logic [3:0] p_ovf;
    sm_t     neg_ii;
    sm_sum_t re_c;
    sm_sum_t im_c;

    // The whole pipe moves as one; bubbles are carried, not squeezed out.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_br    <= '0;
            s1_bi    <= '0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_ar    <= to_sm(bus.a_re, 1'b0);
            s1_ai    <= to_sm(bus.a_im, 1'b0);
            s1_br    <= to_sm(bus.b_re, 1'b0);
            s1_bi    <= to_sm(bus.b_im, bus.conj_b);
            s2_valid <= s1_valid;
        end
    end

    sm_mul_scale #(.MW(MW), .FRAC_W(FRAC_W)) u_rr (
        .clk(clk), .rst(rst), .en(adv), .a(s1_ar), .b(s1_br), .p(p_rr), .ovf(p_ovf[0])
    );
    sm_mul_scale #(.MW(MW), .FRAC_W(FRAC_W)) u_ii (
        .clk(clk), .rst(rst), .en(adv), .a(s1_ai), .b(s1_bi), .p(p_ii), .ovf(p_ovf[1])
    );
    sm_mul_scale #(.MW(MW), .FRAC_W(FRAC_W)) u_ri (
        .clk(clk), .rst(rst), .en(adv), .a(s1_ar), .b(s1_bi), .p(p_ri), .ovf(p_ovf[2])
    );
    sm_mul_scale #(.MW(MW), .FRAC_W(FRAC_W)) u_ir (
        .clk(clk), .rst(rst), .en(adv), .a(s1_ai), .b(s1_br), .p(p_ir), .ovf(p_ovf[3])
    );

    // Subtraction is addition with the subtrahend's sign flipped.
    always_comb begin
        neg_ii      = p_ii;
        neg_ii.sign = ~p_ii.sign;
        re_c        = sm_add(p_rr, neg_ii, MW);
        im_c        = sm_add(p_ri, p_ir, MW);
`ifdef CMULT_SAT_EN
        if (re_c.ovf) begin
            re_c.sum.mag = MAG_MAX;
        end
        if (im_c.ovf) begin
            im_c.sum.mag = MAG_MAX;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.s_re      <= '0;
            bus.s_im      <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= s2_valid;
            bus.s_re      <= from_sm(re_c.sum);
            bus.s_im      <= from_sm(im_c.sum);
            bus.out_ovf   <= (|p_ovf) | re_c.ovf | im_c.ovf;
        end
    end

    // A flagged result leaving the block outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ovf_sticky <= 1'b0;
        end else if (bus.out_valid && bus.out_ready && bus.out_ovf) begin
            bus.ovf_sticky <= 1'b1;
        end else if (bus.ovf_clr) begin
            bus.ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmult_pipe_sm.sv
// Self-checking bench for cmult_pipe_sm at DATA_W=16, FRAC_W=14 (1.0 = 0x4000).
module tb_cmult_pipe_sm;
    localparam int unsigned DW = 16;
    localparam int unsigned FW = 14;
`ifdef CMULT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [15:0] a_re, a_im, b_re, b_im;
        logic        conj;
        logic [15:0] e_re, e_im;
        logic        e_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmult_pipe_sm_if #(.DATA_W(DW)) bus ();
    cmult_pipe_sm #(.DATA_W(DW), .FRAC_W(FW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    vec_t sb[$];
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model in plain signed integer arithmetic.
    function automatic longint prod(input logic [15:0] x, input logic [15:0] y, input bit flip, inout bit ovf);
        longint m;
        bit     neg;
        m   = (longint'(x[14:0]) * longint'(y[14:0])) >> FW;
        neg = x[15] ^ y[15] ^ flip;
        if (m >= 32768) begin
            ovf = 1'b1;
            m   = SAT ? 32767 : m % 32768;
        end
        return neg ? -m : m;
    endfunction

    function automatic logic [15:0] enc(input longint v, inout bit ovf);
        longint m;
        m = (v < 0) ? -v : v;
        if (m >= 32768) begin
            ovf = 1'b1;
            m   = SAT ? 32767 : m % 32768;
        end
        return {(v < 0) && (m != 0), m[14:0]};
    endfunction

    function automatic vec_t mk(input logic [15:0] ar, input logic [15:0] ai,
                                input logic [15:0] br, input logic [15:0] bi, input bit cj);
        vec_t   v;
        bit     o;
        longint rr, ii, ri, ir;
        o  = 1'b0;
        rr = prod(ar, br, 1'b0, o);
        ii = prod(ai, bi, cj, o);
        ri = prod(ar, bi, cj, o);
        ir = prod(ai, br, 1'b0, o);
        v.a_re = ar; v.a_im = ai; v.b_re = br; v.b_im = bi; v.conj = cj;
        v.e_re  = enc(rr - ii, o);
        v.e_im  = enc(ri + ir, o);
        v.e_ovf = o;
        return v;
    endfunction

    function automatic vec_t rnd();
        return mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    endfunction

    // Drive one transaction; returns at the point just after the accepting edge.
    task automatic send(input vec_t v);
        int w;
        w = 0;
        bus.in_valid = 1'b1;
        bus.a_re = v.a_re; bus.a_im = v.a_im; bus.b_re = v.b_re; bus.b_im = v.b_im;
        bus.conj_b = v.conj;
        @(negedge clk);
        while (!bus.in_ready) begin
            w++;
            if (w > 200) begin
                n_chk++; n_fail++;
                $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required 1", w);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        sb.push_back(v);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    // Output monitor: scoreboard compare plus hold-stability while stalled.
    logic        hold = 1'b0;
    logic [15:0] h_re, h_im;
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (bus.out_valid && !bus.out_ready) begin
                if (hold) begin
                    check("hold_s_re", 32'(bus.s_re), 32'(h_re));
                    check("hold_s_im", 32'(bus.s_im), 32'(h_im));
                end
                hold = 1'b1;
                h_re = bus.s_re;
                h_im = bus.s_im;
            end else begin
                hold = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin : pop
                vec_t e;
                n_out++;
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_result: got 0x%0h/0x%0h, required no result", bus.s_re, bus.s_im);
                end else begin
                    e = sb.pop_front();
                    check("s_re", 32'(bus.s_re), 32'(e.e_re));
                    check("s_im", 32'(bus.s_im), 32'(e.e_im));
                    check("out_ovf", 32'(bus.out_ovf), 32'(e.e_ovf));
                end
            end
        end
    end

    initial begin
        int lat;
        int n0;
        int stale;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.ovf_clr = 1'b0; bus.conj_b = 1'b0;
        bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;

        tbl.push_back('{16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0, 16'h0000, 16'h4000, 1'b0});
        tbl.push_back('{16'h2000, 16'h2000, 16'h2000, 16'hA000, 1'b0, 16'h2000, 16'h0000, 1'b0});
        tbl.push_back('{16'h2000, 16'h2000, 16'h2000, 16'h2000, 1'b1, 16'h2000, 16'h0000, 1'b0});
        tbl.push_back('{16'h6000, 16'h0000, 16'h6000, 16'h0000, 1'b0,
                        SAT ? 16'h7FFF : 16'h1000, 16'h0000, 1'b1});
        tbl.push_back('{16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b0,
                        16'h0000, SAT ? 16'h7FFF : 16'h0000, 1'b1});
        tbl.push_back('{16'h4000, 16'h0000, 16'hC000, 16'h0000, 1'b0, 16'hC000, 16'h0000, 1'b0});
        tbl.push_back('{16'h8000, 16'h8000, 16'h1234, 16'h5678, 1'b0, 16'h0000, 16'h0000, 1'b0});
        for (int i = 0; i < 8; i++) tbl.push_back(rnd());

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_s_re", 32'(bus.s_re), 32'd0);
        check("rst_s_im", 32'(bus.s_im), 32'd0);
        check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
        check("rst_ovf_sticky", 32'(bus.ovf_sticky), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Latency of an isolated transaction, counted in edges from acceptance.
        send(tbl[0]);
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        check("latency", 32'(lat), 32'd3);
        drain();

        for (int i = 1; i < tbl.size(); i++) send(tbl[i]);
        bus.in_valid = 1'b0;
        drain();

        @(negedge clk);
        check("sticky_set", 32'(bus.ovf_sticky), 32'd1);
        @(posedge clk); #1;
        bus.ovf_clr = 1'b1;
        @(posedge clk); #1;
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        check("sticky_clr", 32'(bus.ovf_sticky), 32'd0);
        @(posedge clk); #1;

        // Back-to-back stream into a stalled output.
        n0 = n_out;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(rnd());
                bus.in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                check("in_ready_stall", 32'(bus.in_ready), 32'd0);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", 32'(n_out - n0), 32'd6);

        // Overflow transfer coinciding with a clear: the set must win.
        bus.ovf_clr   = 1'b1;
        bus.out_ready = 1'b0;
        send(tbl[3]);
        bus.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!bus.out_valid && lat < 10) begin
            lat++;
            @(negedge clk);
        end
        check("sticky_cleared_pre", 32'(bus.ovf_sticky), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("sticky_set_wins", 32'(bus.ovf_sticky), 32'd1);
        bus.ovf_clr = 1'b0;
        drain();

        // Reset with three transactions in flight.
        bus.out_ready = 1'b0;
        send(tbl[1]);
        send(tbl[3]);
        send(tbl[5]);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst_sticky", 32'(bus.ovf_sticky), 32'd0);
        bus.out_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("stale_after_reset", 32'(stale), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
